// File: rtl/dpb_stream_port_pkg.sv
// -----------------------------------------------------------------------------
// dpb_stream_port_pkg
// Shared constants and types for the dual-port block RAM stream port.
//   ADDR_W  : RAM address width (16384 bytes)
//   DATA_W  : byte width
//   LEN_W   : command length width (0..16384)
//   state_t : burst controller state encoding
//   wraps() : true when a burst would run past the top of the RAM
// -----------------------------------------------------------------------------
package dpb_stream_port_pkg;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 15;

   localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // addr + len is evaluated one bit wider than LEN_W so the sum cannot overflow.
   function automatic logic wraps(input logic [ADDR_W-1:0] addr,
                                  input logic [LEN_W-1:0]  len);
      logic [LEN_W:0] end_pos;
      end_pos = {2'b00, addr} + {1'b0, len};
      return end_pos > (LEN_W+1)'(RAM_DEPTH);
   endfunction

endpackage

// File: rtl/dpb_stream_port_if.sv
// -----------------------------------------------------------------------------
// dpb_stream_port_if
// Host-facing bundle of the stream port: command channel, write stream,
// read stream and status.
//   cmd_*   : command handshake (direction, start address, byte count)
//   wr_*    : write-data valid/ready stream (host -> RAM)
//   rd_*    : read-data valid/ready stream (RAM -> host)
//   busy    : command in progress
//   done    : one-cycle completion pulse
//   err     : one-cycle rejected-command pulse
// Modports: master = host side, slave = dpb_stream_port.
// -----------------------------------------------------------------------------
interface dpb_stream_port_if;
   import dpb_stream_port_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;

   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;

   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;

   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  cmd_ready,
      output wr_valid, wr_data,
      input  wr_ready,
      input  rd_valid, rd_data,
      output rd_ready,
      input  busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      output cmd_ready,
      input  wr_valid, wr_data,
      output wr_ready,
      output rd_valid, rd_data,
      input  rd_ready,
      output busy, done, err
   );

endinterface

// File: rtl/dpb_skid_buf.sv
// -----------------------------------------------------------------------------
// dpb_skid_buf
// Two-entry FIFO that absorbs the RAM read latency and read-stream
// back-pressure. Push and pop in the same cycle are both honoured.
//   clk, resetn : clock, asynchronous active-low reset
//   push        : store push_data
//   push_data   : byte returned by the RAM
//   pop         : discard the head entry
//   head        : oldest stored byte
//   count       : occupancy (0..2)
//   empty, full : occupancy flags
// -----------------------------------------------------------------------------
module dpb_skid_buf
   import dpb_stream_port_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         empty,
   output logic         full
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // NOTE: the two storage entries are reset along with the pointers so that a
   // reset discards buffered bytes and the head reads back as zero.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(do_push) - 2'(do_pop);
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == 2'd0);
   assign full  = (count == 2'd2);

endmodule

// File: rtl/dpb_stream_port.sv
// -----------------------------------------------------------------------------
// dpb_stream_port
// Burst access controller for one port of the 16K x 8 dual-port block RAM
// (bypass read mode, 1-cycle read latency). A command moves cmd_len bytes
// between the host streams and consecutive RAM addresses starting at cmd_addr.
//   clk, resetn       : port clock (shared with RAM), async active-low reset
//   s                 : host bundle (dpb_stream_port_if.slave)
//   ram_ce/oce/wre    : RAM port controls (oce tied 1)
//   ram_reset         : RAM output reset, held 0
//   ram_ad, ram_din   : RAM address and write data
//   ram_dout          : RAM read data
// Optional build macro DPB_STREAM_WRAP_ERR_EN: commands whose span runs past
// address 0x3FFF are rejected with an err pulse. Without it such bursts wrap
// to 0x0000 and err is tied 0.
// -----------------------------------------------------------------------------
module dpb_stream_port
   import dpb_stream_port_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   dpb_stream_port_if.slave   s,
   output logic               ram_ce,
   output logic               ram_oce,
   output logic               ram_wre,
   output logic               ram_reset,
   output logic [ADDR_W-1:0]  ram_ad,
   output logic [DATA_W-1:0]  ram_din,
   input  logic [DATA_W-1:0]  ram_dout
);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  count_q;
   logic              out_en_q;    // keeps cmd_ready low until the first edge after reset
   logic              inflight_q;  // a read was issued last cycle; its byte is on ram_dout now
`ifdef DPB_STREAM_WRAP_ERR_EN
   logic              err_q;
`endif

   logic              cmd_ready;
   logic              cmd_fire;
   logic              wr_beat;
   logic              rd_issue;
   logic              pop;
   logic [2:0]        occ_next;

   logic [DATA_W-1:0] buf_head;
   logic [1:0]        buf_count;
   logic              buf_empty;
   logic              buf_full;

   assign cmd_ready = (state == ST_IDLE) && out_en_q;
   assign cmd_fire  = s.cmd_valid && cmd_ready;
   assign wr_beat   = (state == ST_WRITE) && s.wr_valid;
   assign pop       = !buf_empty && s.rd_ready;

   // Buffer occupancy at the end of this cycle, including the byte arriving
   // from last cycle's read. A new read is only issued if its byte will still
   // fit next cycle, which bounds outstanding reads to two and still allows
   // one read per cycle while the consumer keeps popping.
   assign occ_next = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_issue = (state == ST_READ) && (count_q != '0) && (occ_next < 3'd2);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         out_en_q   <= 1'b0;
         inflight_q <= 1'b0;
`ifdef DPB_STREAM_WRAP_ERR_EN
         err_q      <= 1'b0;
`endif
      end else begin
         out_en_q   <= 1'b1;
         inflight_q <= rd_issue;
`ifdef DPB_STREAM_WRAP_ERR_EN
         err_q      <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (cmd_fire) begin
`ifdef DPB_STREAM_WRAP_ERR_EN
                  if (wraps(s.cmd_addr, s.cmd_len)) begin
                     err_q <= 1'b1;
                  end else
`endif
                  begin
                     addr_q  <= s.cmd_addr;
                     count_q <= s.cmd_len;
                     if (s.cmd_len == '0) begin
                        state <= ST_DONE;
                     end else if (s.cmd_write) begin
                        state <= ST_WRITE;
                     end else begin
                        state <= ST_READ;
                     end
                  end
               end
            end

            ST_WRITE: begin
               if (wr_beat) begin
                  addr_q  <= addr_q + 1'b1;   // wraps 0x3FFF -> 0x0000
                  count_q <= count_q - 1'b1;
                  if (count_q == LEN_W'(1)) begin
                     state <= ST_DONE;
                  end
               end
            end

            ST_READ: begin
               if (rd_issue) begin
                  addr_q  <= addr_q + 1'b1;
                  count_q <= count_q - 1'b1;
                  if (count_q == LEN_W'(1)) begin
                     state <= ST_DRAIN;
                  end
               end
            end

            ST_DRAIN: begin
               if (!inflight_q && buf_empty) begin
                  state <= ST_DONE;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   dpb_skid_buf #(
      .W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .resetn    (resetn),
      .push      (inflight_q),
      .push_data (ram_dout),
      .pop       (pop),
      .head      (buf_head),
      .count     (buf_count),
      .empty     (buf_empty),
      .full      (buf_full)
   );

   // The issue rule must never let a returning byte land in a full buffer.
   assert property (@(posedge clk) disable iff (!resetn)
      !(buf_full && inflight_q && !pop));

   assign s.cmd_ready = cmd_ready;
   assign s.wr_ready  = (state == ST_WRITE);
   assign s.rd_valid  = !buf_empty;
   assign s.rd_data   = buf_head;
   assign s.busy      = (state != ST_IDLE);
   assign s.done      = (state == ST_DONE);
`ifdef DPB_STREAM_WRAP_ERR_EN
   assign s.err       = err_q;
`else
   assign s.err       = 1'b0;
`endif

   assign ram_ce    = wr_beat || rd_issue;
   assign ram_wre   = wr_beat;
   assign ram_ad    = addr_q;
   assign ram_din   = wr_beat ? s.wr_data : '0;
   assign ram_oce   = 1'b1;
   assign ram_reset = 1'b0;

endmodule

// File: tb/tb_dpb_stream_port.sv
// -----------------------------------------------------------------------------
// tb_dpb_stream_port
// Directed bench for dpb_stream_port with a behavioural 16K x 8 RAM port
// (bypass read, 1-cycle latency). Inputs change and outputs are sampled on
// the falling edge; "cycle k" is the k-th falling edge after the one on which
// the command was offered (the command is accepted on the rising edge between).
// -----------------------------------------------------------------------------
module tb_dpb_stream_port;
   import dpb_stream_port_pkg::*;

   logic              clk = 1'b0;
   logic              resetn;
   logic              ram_ce, ram_oce, ram_wre, ram_reset;
   logic [ADDR_W-1:0] ram_ad;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   logic              pre_we;
   logic [ADDR_W-1:0] pre_addr;
   logic [DATA_W-1:0] pre_data;
   logic [DATA_W-1:0] mem [0:RAM_DEPTH-1];

   int n_checks = 0;
   int n_errors = 0;

   dpb_stream_port_if bus ();

   dpb_stream_port dut (
      .clk       (clk),
      .resetn    (resetn),
      .s         (bus),
      .ram_ce    (ram_ce),
      .ram_oce   (ram_oce),
      .ram_wre   (ram_wre),
      .ram_reset (ram_reset),
      .ram_ad    (ram_ad),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   always #5 clk = ~clk;

   // RAM port model; the preload path lets the bench seed contents while idle.
   always @(posedge clk) begin
      if (pre_we) begin
         mem[pre_addr] <= pre_data;
      end else if (ram_ce) begin
         if (ram_wre) mem[ram_ad] <= ram_din;
         else         ram_dout    <= mem[ram_ad];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Offers a command for one cycle; returns at cycle 1.
   task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
      @(negedge clk);
      check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_len = n;
      #1;
      check("ram_ce_idle", 32'(ram_ce), 32'd0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      logic [7:0]        exp8 [8];
      logic [ADDR_W-1:0] wrap_ad [3];
      int issued, got, max_out, outst;
      logic seen_done;

      resetn = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
      bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check("rst_ctrl_zero", 32'({bus.cmd_ready, bus.busy, bus.done, bus.err,
                                  bus.rd_valid, bus.wr_ready, ram_ce, ram_wre}), 32'd0);
      check("rst_ram_ad", 32'(ram_ad), 32'd0);
      check("rst_ram_din", 32'(ram_din), 32'd0);
      check("rst_rd_data", 32'(bus.rd_data), 32'd0);
      check("ram_reset_tied", 32'(ram_reset), 32'd0);
      check("ram_oce_tied", 32'(ram_oce), 32'd1);
      resetn = 1'b1;
      #1 check("cmd_ready_before_edge", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      check("cmd_ready_after_release", 32'(bus.cmd_ready), 32'd1);

      // ---- write len=4 at 0x0010, no stalls ----
      send_cmd(1'b1, 14'h0010, 15'd4);
      for (int i = 0; i < 4; i++) begin
         bus.wr_valid = 1'b1; bus.wr_data = 8'hA1 + 8'(i);
         #1;
         check("wr_ready", 32'(bus.wr_ready), 32'd1);
         check("wr_ce_wre", 32'({ram_ce, ram_wre}), 32'd3);
         check("wr_ad", 32'(ram_ad), 32'h10 + 32'(i));
         check("wr_din", 32'(ram_din), 32'hA1 + 32'(i));
         check("wr_no_early_done", 32'(bus.done), 32'd0);
         @(negedge clk);
      end
      bus.wr_valid = 1'b0;
      #1 check("wr_done_cycle5", 32'(bus.done), 32'd1);
      @(negedge clk);
      check("wr_done_one_cycle", 32'({bus.done, bus.busy}), 32'd0);
      check("wr_mem10", 32'(mem[14'h10]), 32'hA1);
      check("wr_mem11", 32'(mem[14'h11]), 32'hA2);
      check("wr_mem12", 32'(mem[14'h12]), 32'hA3);
      check("wr_mem13", 32'(mem[14'h13]), 32'hA4);

      // ---- read len=4 at 0x0010, rd_ready held high ----
      bus.rd_ready = 1'b1;
      send_cmd(1'b0, 14'h0010, 15'd4);
      #1;
      check("rd_issue_ce_wre", 32'({ram_ce, ram_wre}), 32'd2);
      check("rd_issue_ad", 32'(ram_ad), 32'h10);
      check("rd_c1_not_valid", 32'(bus.rd_valid), 32'd0);
      @(negedge clk);
      check("rd_c2_not_valid", 32'(bus.rd_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rd4_valid", 32'(bus.rd_valid), 32'd1);
         check("rd4_data", 32'(bus.rd_data), 32'hA1 + 32'(i));
      end
      wait_done("rd4_done", 20);
      bus.rd_ready = 1'b0;

      // ---- read len=8 with rd_ready toggling ----
      poke(14'h0014, 8'hB5); poke(14'h0015, 8'hB6);
      poke(14'h0016, 8'hB7); poke(14'h0017, 8'hB8);
      exp8[0] = 8'hA1; exp8[1] = 8'hA2; exp8[2] = 8'hA3; exp8[3] = 8'hA4;
      exp8[4] = 8'hB5; exp8[5] = 8'hB6; exp8[6] = 8'hB7; exp8[7] = 8'hB8;
      issued = 0; got = 0; max_out = 0; seen_done = 1'b0;
      send_cmd(1'b0, 14'h0010, 15'd8);
      for (int cyc = 0; cyc < 80 && !seen_done; cyc++) begin
         bus.rd_ready = cyc[0];
         #1;
         if (ram_ce && !ram_wre) issued++;
         if (bus.rd_valid && bus.rd_ready) begin
            if (got < 8) check("rd8_data", 32'(bus.rd_data), 32'(exp8[got]));
            got++;
         end
         outst = issued - got;
         if (outst > max_out) max_out = outst;
         if (bus.done) seen_done = 1'b1;
         @(negedge clk);
      end
      bus.rd_ready = 1'b0;
      check("rd8_done", 32'(seen_done), 32'd1);
      check("rd8_byte_count", 32'(got), 32'd8);
      check("rd8_issue_count", 32'(issued), 32'd8);
      check("rd8_outstanding_le2", 32'(max_out <= 2), 32'd1);

      // ---- write len=3 at 0x3FFE (crosses the top of the RAM) ----
      poke(14'h3FFE, 8'h55); poke(14'h3FFF, 8'h55); poke(14'h0000, 8'h55);
      send_cmd(1'b1, 14'h3FFE, 15'd3);
`ifndef DPB_STREAM_WRAP_ERR_EN
      wrap_ad[0] = 14'h3FFE; wrap_ad[1] = 14'h3FFF; wrap_ad[2] = 14'h0000;
      for (int i = 0; i < 3; i++) begin
         bus.wr_valid = 1'b1; bus.wr_data = 8'hC1 + 8'(i);
         #1;
         check("wrap_ce", 32'(ram_ce), 32'd1);
         check("wrap_ad", 32'(ram_ad), 32'(wrap_ad[i]));
         @(negedge clk);
      end
      bus.wr_valid = 1'b0;
      #1 check("wrap_done", 32'(bus.done), 32'd1);
      check("wrap_err_tied", 32'(bus.err), 32'd0);
      @(negedge clk);
      check("wrap_mem3ffe", 32'(mem[14'h3FFE]), 32'hC1);
      check("wrap_mem3fff", 32'(mem[14'h3FFF]), 32'hC2);
      check("wrap_mem0000", 32'(mem[14'h0000]), 32'hC3);
`else
      wrap_ad[0] = '0; wrap_ad[1] = '0; wrap_ad[2] = '0;
      bus.wr_valid = 1'b1; bus.wr_data = 8'hC1;
      #1;
      check("rej_err_pulse", 32'(bus.err), 32'd1);
      check("rej_idle", 32'({bus.busy, bus.cmd_ready}), 32'd1);
      check("rej_no_ce", 32'(ram_ce), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("rej_err_one_cycle", 32'(bus.err), 32'd0);
         check("rej_no_done", 32'(bus.done), 32'd0);
         check("rej_no_ce_later", 32'(ram_ce), 32'd0);
      end
      bus.wr_valid = 1'b0;
      check("rej_mem3ffe", 32'(mem[14'h3FFE]), 32'h55);
      check("rej_mem3fff", 32'(mem[14'h3FFF]), 32'h55);
      check("rej_mem0000", 32'(mem[14'h0000]), 32'h55);
`endif

      // ---- len=0 command ----
      send_cmd(1'b1, 14'h0100, 15'd0);
      #1;
      check("len0_done_cycle1", 32'(bus.done), 32'd1);
      check("len0_no_ce", 32'(ram_ce), 32'd0);
      @(negedge clk);
      check("len0_back_idle", 32'({bus.done, bus.busy, bus.cmd_ready}), 32'd1);

      // ---- reset during a len=16 read after 5 bytes ----
      bus.rd_ready = 1'b1;
      got = 0;
      send_cmd(1'b0, 14'h0010, 15'd16);
      for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
         #1;
         if (bus.rd_valid) got++;
         if (got < 5) @(negedge clk);
      end
      check("rst_mid_bytes_seen", 32'(got), 32'd5);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("rst_mid_ctrl_zero", 32'({bus.cmd_ready, bus.busy, bus.done, bus.err,
                                      bus.rd_valid, bus.wr_ready, ram_ce, ram_wre}), 32'd0);
      check("rst_mid_ad_din", 32'({ram_ad, ram_din}), 32'd0);
      check("rst_mid_rd_data", 32'(bus.rd_data), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_mid_after_release", 32'({bus.done, bus.busy, bus.rd_valid, bus.cmd_ready}), 32'd1);
      bus.rd_ready = 1'b0;

      // next command runs normally
      send_cmd(1'b1, 14'h0030, 15'd2);
      bus.wr_valid = 1'b1; bus.wr_data = 8'hD1;
      @(negedge clk);
      bus.wr_data = 8'hD2;
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1 check("post_rst_done_cycle3", 32'(bus.done), 32'd1);
      @(negedge clk);
      check("post_rst_mem30", 32'(mem[14'h0030]), 32'hD1);
      check("post_rst_mem31", 32'(mem[14'h0031]), 32'hD2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
